line_serdes: RTL



---
 rtl/line_serdes.sv | 121 ++++++++++++
 1 files changed

// File: rtl/line_serdes.sv
// Cache-line serializer/deserializer between the line buffer and the word-wide memory bus.
// The two halves are independent; each uses valid/ready handshakes on both sides.
module line_serdes #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned WORD_W = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ser_line_valid,
    output logic                           ser_line_ready,
    input  logic [LINE_W-1:0]              ser_line_data,
    output logic                           ser_word_valid,
    input  logic                           ser_word_ready,
    output logic [WORD_W-1:0]              ser_word_data,
    output logic [$clog2(LINE_W/WORD_W)-1:0] ser_word_idx,
    output logic                           ser_word_last,
    output logic                           ser_done,
    input  logic                           des_word_valid,
    output logic                           des_word_ready,
    input  logic [WORD_W-1:0]              des_word_data,
    output logic                           des_line_valid,
    input  logic                           des_line_ready,
    output logic [LINE_W-1:0]              des_line_data,
    output logic                           busy
);
    localparam int unsigned WORDS = LINE_W / WORD_W;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;
    localparam logic [0:0] D_FILL = 1'b0;
    localparam logic [0:0] D_HOLD = 1'b1;

    logic [0:0]                   ser_state_q, ser_state_d;
    logic [IDX_W-1:0]             ser_idx_q, ser_idx_d;
    logic [WORDS-1:0][WORD_W-1:0] ser_line_q, ser_line_d;
    logic                         ser_done_q, ser_done_d;

    logic [0:0]                   des_state_q, des_state_d;
    logic [IDX_W-1:0]             des_cnt_q, des_cnt_d;
    logic [WORDS-1:0][WORD_W-1:0] des_line_q, des_line_d;

    logic ser_line_xfer, ser_word_xfer, des_word_xfer, des_line_xfer;

    // Handshake outputs depend only on state and reset, never on the opposite ready.
    assign ser_line_ready = rst_n & (ser_state_q == S_IDLE);
    assign ser_word_valid = rst_n & (ser_state_q == S_SEND);
    assign ser_word_data  = ser_line_q[ser_idx_q];
    assign ser_word_idx   = ser_idx_q;
    assign ser_word_last  = (ser_state_q == S_SEND) & (ser_idx_q == LAST_IDX);
    assign ser_done       = rst_n & ser_done_q;

    assign des_word_ready = rst_n & (des_state_q == D_FILL);
    assign des_line_valid = rst_n & (des_state_q == D_HOLD);
    assign des_line_data  = des_line_q;

    assign busy = rst_n & ((ser_state_q == S_SEND) | (des_state_q == D_HOLD) | (des_cnt_q != '0));

    assign ser_line_xfer = ser_line_valid & ser_line_ready;
    assign ser_word_xfer = ser_word_valid & ser_word_ready;
    assign des_word_xfer = des_word_valid & des_word_ready;
    assign des_line_xfer = des_line_valid & des_line_ready;

    always_comb begin
        ser_state_d = ser_state_q;
        ser_idx_d   = ser_idx_q;
        ser_line_d  = ser_line_q;
        ser_done_d  = 1'b0;
        if (ser_line_xfer) begin
            ser_line_d  = ser_line_data;
            ser_idx_d   = '0;
            ser_state_d = S_SEND;
        end else if (ser_word_xfer) begin
            if (ser_idx_q == LAST_IDX) begin
                ser_state_d = S_IDLE;
                ser_done_d  = 1'b1;
            end else begin
                ser_idx_d = ser_idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        des_state_d = des_state_q;
        des_cnt_d   = des_cnt_q;
        des_line_d  = des_line_q;
        if (des_word_xfer) begin
            des_line_d[des_cnt_q] = des_word_data;
            if (des_cnt_q == LAST_IDX) begin
                des_cnt_d   = '0;
                des_state_d = D_HOLD;
            end else begin
                des_cnt_d = des_cnt_q + IDX_W'(1);
            end
        end else if (des_line_xfer) begin
            des_state_d = D_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ser_state_q <= S_IDLE;
            ser_idx_q   <= '0;
            ser_line_q  <= '0;
            ser_done_q  <= 1'b0;
            des_state_q <= D_FILL;
            des_cnt_q   <= '0;
            des_line_q  <= '0;
        end else begin
            ser_state_q <= ser_state_d;
            ser_idx_q   <= ser_idx_d;
            ser_line_q  <= ser_line_d;
            ser_done_q  <= ser_done_d;
            des_state_q <= des_state_d;
            des_cnt_q   <= des_cnt_d;
            des_line_q  <= des_line_d;
        end
    end

endmodule
